// File: rtl/thermo_disp_pkg.sv
// Shared types and helpers for the display zone scheduler.
package thermo_disp_pkg;

    typedef enum logic [1:0] {
        SCAN_M,
        SCAN_C,
        MANUAL,
        ALARM
    } disp_state_t;

    localparam logic ZONE_MANOR  = 1'b0;
    localparam logic ZONE_CELLAR = 1'b1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Wrapping dwell counter 0..CYCLES-1 with synchronous clear and terminal-count flag.
module disp_dwell_timer
    import thermo_disp_pkg::*;
#(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned W = cnt_width(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/display_zone_scheduler.sv
// Zone selection for the display driver: auto-scan, manual select and window-alarm preemption.
// Blink generation is built only when DISP_SCHED_BLINK_EN is defined; otherwise blink is tied 0.
module display_zone_scheduler
    import thermo_disp_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned ALARM_HOLD   = 4,
    parameter int unsigned BLINK_DIV    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic auto_en,
    input  logic ID_SW,
    input  logic nWSM,
    input  logic nWSC,
    output logic zone_sel,
    output logic alarm_active,
    output logic blink,
    output logic zone_chg
);

    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 2");
    end
    if (ALARM_HOLD < 1) begin : g_bad_hold
        $error("ALARM_HOLD must be at least 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("BLINK_DIV must be at least 1");
    end

    localparam int unsigned HW = cnt_width(ALARM_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ALARM_HOLD - 1);

    disp_state_t   state, state_next;
    logic          zone_next;
    logic          dwell_clr, dwell_en, dwell_tc;
    logic          dual_q;
    logic [HW-1:0] hold_cnt;
    logic          any_open, both_open, hold_done;

    assign any_open  = !nWSM || !nWSC;
    assign both_open = !nWSM && !nWSC;
    assign hold_done = (hold_cnt >= HOLD_LAST);

    disp_dwell_timer #(
        .CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (dwell_clr),
        .enable (dwell_en),
        .tc     (dwell_tc)
    );

    always_comb begin
        state_next = state;
        zone_next  = zone_sel;
        dwell_en   = 1'b0;
        dwell_clr  = 1'b1;
        if (state == ALARM) begin
            if (!any_open && hold_done) begin
                if (auto_en) begin
                    state_next = zone_sel ? SCAN_C : SCAN_M;
                end else begin
                    state_next = MANUAL;
                end
            end else if (both_open) begin
                // First cycle with both open restarts alternation from the shown zone.
                if (dual_q) begin
                    dwell_en  = 1'b1;
                    dwell_clr = 1'b0;
                    if (dwell_tc) begin
                        zone_next = ~zone_sel;
                    end
                end
            end else if (!nWSM) begin
                zone_next = ZONE_MANOR;
            end else if (!nWSC) begin
                zone_next = ZONE_CELLAR;
            end
        end else if (any_open) begin
            state_next = ALARM;
            zone_next  = !nWSM ? ZONE_MANOR : ZONE_CELLAR;
        end else if (!auto_en) begin
            state_next = MANUAL;
            zone_next  = ID_SW;
        end else if (state == MANUAL) begin
            state_next = zone_sel ? SCAN_C : SCAN_M;
        end else begin
            dwell_en  = 1'b1;
            dwell_clr = 1'b0;
            if (dwell_tc) begin
                zone_next  = ~zone_sel;
                state_next = (state == SCAN_M) ? SCAN_C : SCAN_M;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SCAN_M;
            zone_sel     <= ZONE_MANOR;
            alarm_active <= 1'b0;
            zone_chg     <= 1'b0;
            dual_q       <= 1'b0;
        end else begin
            state        <= state_next;
            zone_sel     <= zone_next;
            alarm_active <= (state_next == ALARM);
            zone_chg     <= (zone_next != zone_sel);
            dual_q       <= (state_next == ALARM) && both_open;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ALARM) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

`ifdef DISP_SCHED_BLINK_EN
    localparam int unsigned BKW = cnt_width(BLINK_DIV);
    localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_DIV - 1);

    logic [BKW-1:0] blink_cnt;
    logic           blink_q;

    always_ff @(posedge clk) begin
        if (rst || state != ALARM || state_next != ALARM) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_display_zone_scheduler.sv
// Randomized self-checking bench for display_zone_scheduler against a timeline-based reference model.
module tb_display_zone_scheduler;

    localparam int D = 8;
    localparam int H = 4;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst, auto_en, id_sw, nwsm, nwsc;
    logic zone_sel, alarm_active, blink, zone_chg;

    int checks = 0;
    int errors = 0;

    display_zone_scheduler #(
        .DWELL_CYCLES(D),
        .ALARM_HOLD  (H),
        .BLINK_DIV   (B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .auto_en      (auto_en),
        .ID_SW        (id_sw),
        .nWSM         (nwsm),
        .nWSC         (nwsc),
        .zone_sel     (zone_sel),
        .alarm_active (alarm_active),
        .blink        (blink),
        .zone_chg     (zone_chg)
    );

    always #5 clk = ~clk;

    // Reference: zones derived from elapsed time since a phase start, blink from alarm age.
    typedef enum {M_SCAN, M_MANUAL, M_ALARM} mode_t;
    mode_t m_mode       = M_SCAN;
    bit    m_zone       = 1'b0;
    bit    m_chg        = 1'b0;
    bit    m_blink      = 1'b0;
    bit    m_dual       = 1'b0;
    bit    m_phase_zone = 1'b0;
    int    m_phase_t    = 0;
    int    m_age        = 0;

    task automatic model_step();
        bit prev = m_zone;
        bit any  = !nwsm || !nwsc;
        bit both = !nwsm && !nwsc;
        if (rst) begin
            m_mode = M_SCAN; m_zone = 1'b0; m_chg = 1'b0; m_blink = 1'b0;
            m_dual = 1'b0; m_phase_zone = 1'b0; m_phase_t = 0; m_age = 0;
            return;
        end
        if (m_mode == M_ALARM) begin
            if (!any && m_age >= H - 1) begin
                m_mode = auto_en ? M_SCAN : M_MANUAL;
                m_phase_t = 0; m_phase_zone = m_zone; m_dual = 1'b0;
            end else begin
                if (both) begin
                    if (!m_dual) begin
                        m_dual = 1'b1; m_phase_t = 0; m_phase_zone = m_zone;
                    end else begin
                        m_phase_t++;
                        m_zone = m_phase_zone ^ bit'((m_phase_t / D) % 2);
                    end
                end else begin
                    m_dual = 1'b0;
                    if (any) m_zone = nwsm ? 1'b1 : 1'b0;
                end
                m_age++;
            end
        end else if (any) begin
            m_mode = M_ALARM; m_age = 0; m_zone = !nwsm ? 1'b0 : 1'b1;
            m_dual = both; m_phase_t = 0; m_phase_zone = m_zone;
        end else if (!auto_en) begin
            m_mode = M_MANUAL; m_zone = id_sw;
        end else if (m_mode == M_MANUAL) begin
            m_mode = M_SCAN; m_phase_t = 0; m_phase_zone = m_zone;
        end else begin
            m_phase_t++;
            m_zone = m_phase_zone ^ bit'((m_phase_t / D) % 2);
        end
        m_chg = (m_zone != prev);
`ifdef DISP_SCHED_BLINK_EN
        m_blink = (m_mode == M_ALARM) ? bit'((m_age / B) % 2) : 1'b0;
`else
        m_blink = 1'b0;
`endif
    endtask

    function automatic logic [3:0] exp_vec();
        return {m_zone, (m_mode == M_ALARM), m_blink, m_chg};
    endfunction

    function automatic logic [3:0] obs();
        return {zone_sel, alarm_active, blink, zone_chg};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; auto_en = 1'b1; id_sw = 1'b0; nwsm = 1'b1; nwsc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL reset cyc %0d got %b want 0000", i, obs());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        auto_en = 1'b1; nwsm = 1'b1; nwsc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL scan cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_manual();
        auto_en = 1'b0; id_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL manual_settle cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
        id_sw = 1'b1;
        tick();
        checks++;
        if ({zone_sel, zone_chg} !== 2'b11) begin
            errors++;
            $display("FAIL manual_select got zone=%b chg=%b want zone=1 chg=1", zone_sel, zone_chg);
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) id_sw = ~id_sw;
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL manual cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_single_alarm();
        int alarm_cycles = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        auto_en = 1'b1; nwsm = 1'b1; nwsc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            nwsc = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            if (alarm_active === 1'b1) alarm_cycles++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL single_alarm cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
        checks++;
        if (alarm_cycles !== 4) begin
            errors++;
            $display("FAIL alarm_len got %0d want 4", alarm_cycles);
        end
    endtask

    task automatic test_dual_alarm();
        rst = 1'b1; tick(); rst = 1'b0;
        auto_en = 1'b1; nwsm = 1'b0; nwsc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 40) begin nwsm = 1'b1; nwsc = 1'b1; end
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL dual_alarm cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_alarm();
        nwsc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset_alarm cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_alarm got %b want 0000", obs());
        end
        rst = 1'b0; nwsc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 4) == 0) id_sw = ~id_sw;
            if ($urandom_range(0, 9) == 0) nwsm = ~nwsm;
            if ($urandom_range(0, 9) == 0) nwsc = ~nwsc;
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, obs(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; auto_en = 1'b1; id_sw = 1'b0; nwsm = 1'b1; nwsc = 1'b1;
        test_reset();
        test_scan();
        test_manual();
        test_single_alarm();
        test_dual_alarm();
        test_reset_mid_alarm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
